// File: rtl/reg_writeback.sv
// Register-file writeback stage: commits ALU results and load data to the
// register file, tracks the pending destination and flags memory errors.
module reg_writeback #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] Instr,
  input  logic [31:0] alu_result,
  input  logic        RegWrite,
  input  logic        RegDst,
  input  logic        MemtoReg,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        WE3,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic        pend_valid,
  output logic [4:0]  pend_reg,
  input  logic        err_clr,
  output logic [1:0]  err,
  output logic [15:0] wb_count
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    WRITE
  } state_t;

  localparam logic [7:0] TLIM = 8'(TIMEOUT);

  state_t      state, state_n;
  logic [4:0]  dest, dest_q, dest_n;
  logic [31:0] data_q, data_n;
  logic        keep_q, keep_n;
  logic [7:0]  tcnt_q, tcnt_n, tcnt_inc;
  logic [1:0]  err_n;
  logic [15:0] count_n;
  logic        accept, real_wr;
  logic        unused_bits;

  assign unused_bits = ^{Instr[31:21], Instr[10:0]};

  assign dest     = RegDst ? Instr[15:11] : Instr[20:16];
  assign real_wr  = RegWrite && (dest != 5'd0);
  assign in_ready = (state != WAIT_MEM);
  assign accept   = in_valid && in_ready;
  assign tcnt_inc = tcnt_q + 8'd1;

  always_comb begin
    state_n = state;
    dest_n  = dest_q;
    data_n  = data_q;
    keep_n  = keep_q;
    tcnt_n  = tcnt_q;
    count_n = wb_count;
    err_n   = err_clr ? 2'b00 : err;
    unique case (1'b1)
      (state == WAIT_MEM): begin
        if (mem_rvalid) begin
          data_n  = mem_rdata;
          state_n = keep_q ? WRITE : IDLE;
        end else begin
          tcnt_n = tcnt_inc;
          if (tcnt_inc >= TLIM) begin
            err_n[0] = 1'b1;
            state_n  = IDLE;
          end
        end
      end
      default: begin
        if (state == WRITE) count_n = wb_count + 16'd1;
        // a response with no load outstanding is spurious
        if (mem_rvalid) err_n[1] = 1'b1;
        state_n = IDLE;
        if (accept) begin
          if (MemtoReg) begin
            state_n = WAIT_MEM;
            dest_n  = dest;
            keep_n  = real_wr;
            tcnt_n  = 8'd0;
          end else if (real_wr) begin
            state_n = WRITE;
            dest_n  = dest;
            data_n  = alu_result;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      dest_q   <= '0;
      data_q   <= '0;
      keep_q   <= 1'b0;
      tcnt_q   <= '0;
      err      <= '0;
      wb_count <= '0;
    end else begin
      state    <= state_n;
      dest_q   <= dest_n;
      data_q   <= data_n;
      keep_q   <= keep_n;
      tcnt_q   <= tcnt_n;
      err      <= err_n;
      wb_count <= count_n;
    end
  end

  assign WE3        = (state == WRITE);
  assign A3         = WE3 ? dest_q : 5'd0;
  assign WD3        = WE3 ? data_q : 32'd0;
  assign pend_valid = WE3 || ((state == WAIT_MEM) && keep_q);
  assign pend_reg   = pend_valid ? dest_q : 5'd0;

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: expected writes go into a scoreboard queue,
// a monitor pops and compares on every WE3 pulse.
module tb_reg_writeback;

  logic        clk = 0;
  logic        reset = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] Instr = 0;
  logic [31:0] alu_result = 0;
  logic        RegWrite = 0;
  logic        RegDst = 0;
  logic        MemtoReg = 0;
  logic        mem_rvalid = 0;
  logic [31:0] mem_rdata = 0;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        pend_valid;
  logic [4:0]  pend_reg;
  logic        err_clr = 0;
  logic [1:0]  err;
  logic [15:0] wb_count;

  int checks = 0;
  int errors = 0;
  logic [36:0] sb[$];
  logic [15:0] exp_wb = 0;

  reg_writeback #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .Instr(Instr), .alu_result(alu_result),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .WE3(WE3), .A3(A3), .WD3(WD3),
    .pend_valid(pend_valid), .pend_reg(pend_reg),
    .err_clr(err_clr), .err(err), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && WE3) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got A3=%0d WD3=%h expected none",
                 A3, WD3);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        if ({A3, WD3} !== e) begin
          errors++;
          $display("FAIL write: got A3=%0d WD3=%h expected A3=%0d WD3=%h",
                   A3, WD3, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] ins, input logic [31:0] alu,
                       input logic rw, input logic rd, input logic m2r);
    in_valid = 1; Instr = ins; alu_result = alu;
    RegWrite = rw; RegDst = rd; MemtoReg = m2r;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] alu,
                       input logic rw, input logic rd, input logic m2r);
    @(posedge clk); #1;
    drive(ins, alu, rw, rd, m2r);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    sb.push_back({a, d});
    exp_wb++;
  endtask

  task automatic clear_err;
    @(posedge clk); #1; err_clr = 1;
    @(posedge clk); #1; err_clr = 0;
  endtask

  initial begin
    int n;
    #2;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_we3", 32'(WE3), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_wb_count", 32'(wb_count), 0);
    chk("rst_pend", 32'({pend_valid, pend_reg}), 0);
    #10 reset = 1;

    // single ALU write, rd=10
    expect_wr(5'd10, 32'h8);
    issue(32'h01095020, 32'h8, 1, 1, 0);
    @(posedge clk); #1;
    chk("alu_wb_count", 32'(wb_count), 32'(exp_wb));

    // load rt=9, response three cycles after accept
    issue(32'h8C090004, 32'h0, 1, 0, 1);
    @(negedge clk);
    chk("ld_in_ready", 32'(in_ready), 0);
    chk("ld_pend_valid", 32'(pend_valid), 1);
    chk("ld_pend_reg", 32'(pend_reg), 9);
    repeat (2) @(posedge clk);
    #1; mem_rvalid = 1; mem_rdata = 32'hFFFF1234;
    expect_wr(5'd9, 32'hFFFF1234);
    @(posedge clk); #1; mem_rvalid = 0;
    @(posedge clk); #1;
    chk("ld_wb_count", 32'(wb_count), 32'(exp_wb));

    // four back-to-back ALU ops rd=1..4
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) begin
      drive(32'(i) << 11, 32'h100 + 32'(i), 1, 1, 0);
      expect_wr(5'(i), 32'h100 + 32'(i));
      @(posedge clk); #1;
    end
    in_valid = 0;
    @(posedge clk); #1;
    chk("b2b_drained", 32'(sb.size()), 0);
    chk("b2b_wb_count", 32'(wb_count), 32'(exp_wb));

    // load with no response: timeout after 15 wait cycles
    issue(32'h8C090004, 32'h0, 1, 0, 1);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("to_wait_cycles", 32'(n), 15);
    chk("to_err", 32'(err), 32'b01);
    chk("to_wb_count", 32'(wb_count), 32'(exp_wb));
    clear_err;
    chk("to_err_clr", 32'(err), 0);

    // ALU op to r0, then spurious response in IDLE
    issue(32'h00000000, 32'h55, 1, 1, 0);
    @(posedge clk); #1; mem_rvalid = 1; mem_rdata = 32'hDEAD;
    @(posedge clk); #1; mem_rvalid = 0;
    chk("spur_err", 32'(err), 32'b10);
    chk("spur_wb_count", 32'(wb_count), 32'(exp_wb));
    clear_err;

    // load with RegWrite=0: waits, response discarded
    issue(32'h8C0A0004, 32'h0, 0, 0, 1);
    @(negedge clk);
    chk("disc_in_ready", 32'(in_ready), 0);
    chk("disc_pend_valid", 32'(pend_valid), 0);
    @(posedge clk); #1; mem_rvalid = 1; mem_rdata = 32'h1;
    @(posedge clk); #1; mem_rvalid = 0;
    chk("disc_in_ready_after", 32'(in_ready), 1);
    chk("disc_err", 32'(err), 0);
    @(posedge clk); #1;
    chk("disc_wb_count", 32'(wb_count), 32'(exp_wb));

    // reset while waiting on a load
    issue(32'h8C090004, 32'h0, 1, 0, 1);
    @(posedge clk); #1;
    reset = 0; exp_wb = 0;
    #1;
    chk("mr_in_ready", 32'(in_ready), 1);
    chk("mr_pend", 32'({pend_valid, pend_reg}), 0);
    chk("mr_we3", 32'(WE3), 0);
    chk("mr_wb_count", 32'(wb_count), 0);
    #5 reset = 1;
    @(posedge clk); #1; mem_rvalid = 1; mem_rdata = 32'h77;
    @(posedge clk); #1; mem_rvalid = 0;
    @(posedge clk); #1;
    chk("mr_err", 32'(err), 32'b10);
    chk("mr_wb_count_after", 32'(wb_count), 0);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
